// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for cnn_top: walks a 28x28 image one pixel per cycle and counts pooled beats until the frame is done.
// Latency: first read 1 cycle after i_start, pixel 1 cycle after its read, o_done 1 cycle after the last pool beat.
// Backpressure: i_hold stalls new reads; one in-flight pixel may still arrive. Optional watchdog: CNN_SEQ_TIMEOUT_EN.
module cnn_frame_sequencer #(
  parameter int I_F_BW  = 8,
  parameter int IX      = 28,
  parameter int IY      = 28,
  parameter int KX      = 5,
  parameter int KY      = 5,
  parameter int TIMEOUT = 4096,
  localparam int NPIX   = IX * IY,
  localparam int NPOOL  = ((IX - KX + 1) / 2) * ((IY - KY + 1) / 2),
  localparam int AW     = $clog2(NPIX),
  localparam int PW     = $clog2(NPOOL + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_rd_en,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [I_F_BW-1:0] i_rd_data,
  output logic              o_pixel_valid,
  output logic [I_F_BW-1:0] o_pixel,
  input  logic              i_pool_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   pool_q, pool_d;
  logic            done_q, done_d;
  logic            pv_q;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pool_d  = pool_q;
    done_d  = 1'b0;
    o_rd_en = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FEED;
          addr_d  = '0;
          pool_d  = '0;
        end
      end
      FEED: begin
        if (!i_hold) begin
          o_rd_en = 1'b1;
          addr_d  = addr_q + AW'(1);
          if (addr_q == AW'(NPIX - 1)) begin
            state_d = DRAIN;
`ifdef CNN_SEQ_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
        // Early pool beats still count; saturate so a surplus cannot wrap.
        if (i_pool_valid && pool_q != PW'(NPOOL))
          pool_d = pool_q + PW'(1);
      end
      DRAIN: begin
        if (i_pool_valid && pool_q != PW'(NPOOL))
          pool_d = pool_q + PW'(1);
`ifdef CNN_SEQ_TIMEOUT_EN
        wd_d = i_pool_valid ? '0 : wd_q + WW'(1);
`endif
        if (pool_d == PW'(NPOOL)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef CNN_SEQ_TIMEOUT_EN
        else if (wd_d == WW'(TIMEOUT)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pool_q  <= '0;
      done_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pool_q  <= pool_d;
      done_q  <= done_d;
      pv_q    <= o_rd_en;
    end
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_rd_addr     = addr_q;
  assign o_pixel_valid = pv_q;
  assign o_pixel       = i_rd_data;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: a vector table for the first cycles, then frame-level sequences.
module tb_cnn_frame_sequencer;

  localparam int NPIX  = 784;
  localparam int NPOOL = 144;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start, i_hold, i_pool_valid;
  logic       o_rd_en, o_pixel_valid, o_busy, o_done, o_err;
  logic [9:0] o_rd_addr;
  logic [7:0] i_rd_data, o_pixel;

  int n_checks = 0;
  int n_fail   = 0;

  cnn_frame_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_hold(i_hold),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_pixel_valid(o_pixel_valid), .o_pixel(o_pixel), .i_pool_valid(i_pool_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Image memory model: one-cycle read latency.
  always @(posedge clk) if (o_rd_en) i_rd_data <= mem_fn(int'(o_rd_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge; outputs are then observed 1ns before the next rising edge.
  task automatic tick(input logic st, input logic hd, input logic pv);
    @(negedge clk);
    i_start = st; i_hold = hd; i_pool_valid = pv;
    #4;
  endtask

  task automatic feed_frame(input int hold_addr, input int hold_len, input int restart_cyc,
                            input int pool_n, output int last_cyc, output int hold_pv);
    int exp_addr = 0, cyc = 0, held = 0, prev_addr = 0, errs = 0;
    logic prev_rd = 1'b0, hd;
    last_cyc = -1;
    hold_pv  = 0;
    tick(1'b1, 1'b0, 1'b0);
    chk("start_idle_busy", o_busy, 0);
    while (exp_addr < NPIX && cyc < 2 * NPIX) begin
      cyc++;
      hd = (exp_addr == hold_addr) && (held < hold_len);
      tick(cyc == restart_cyc, hd, cyc <= pool_n);
      if (o_pixel_valid !== prev_rd) errs++;
      if (prev_rd && o_pixel !== mem_fn(prev_addr)) errs++;
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_err !== 1'b0) errs++;
      if (hd) begin
        held++;
        if (o_pixel_valid) hold_pv++;
        if (o_rd_en !== 1'b0 || o_rd_addr !== 10'(exp_addr)) errs++;
        prev_rd = 1'b0;
      end else begin
        if (o_rd_en !== 1'b1 || o_rd_addr !== 10'(exp_addr)) errs++;
        prev_rd   = 1'b1;
        prev_addr = exp_addr;
        last_cyc  = cyc;
        exp_addr++;
      end
    end
    chk("feed_cycle_errs", errs, 0);
    chk("feed_reads_issued", exp_addr, NPIX);
    tick(1'b0, 1'b0, 1'b0);
    chk("last_pixel_valid", o_pixel_valid, 1);
    chk("last_pixel_data", o_pixel, mem_fn(NPIX - 1));
    chk("drain_no_read", o_rd_en, 0);
    chk("drain_busy", o_busy, 1);
  endtask

  task automatic drain(input int n, input logic start_on_done);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (o_done !== 1'b0 || o_busy !== 1'b1) errs++;
    end
    chk("drain_before_done", errs, 0);
    tick(start_on_done, 1'b0, 1'b0);
    chk("done_pulse", o_done, 1);
    chk("done_busy_low", o_busy, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("done_single", o_done, 0);
    if (start_on_done) begin
      chk("restart_rd_en", o_rd_en, 1);
      chk("restart_addr", o_rd_addr, 0);
      chk("restart_busy", o_busy, 1);
    end else begin
      chk("idle_after_done", o_busy, 0);
    end
  endtask

  typedef struct {
    logic       st, hd, pv_in;
    logic       e_rd;
    int         e_addr;
    logic       e_pv;
    logic [7:0] e_pix;
    logic       e_busy, e_done;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int last, hpv, errs, k;
    // {start, hold, pool | rd_en, addr, pix_valid, pixel, busy, done}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd0,  1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'd0,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd0,  1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'd3,  1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'd10, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 8'd17, 1'b1, 1'b0};

    reset_n = 1'b0; i_start = 1'b0; i_hold = 1'b0; i_pool_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].st, tbl[i].hd, tbl[i].pv_in);
      chk($sformatf("v%0d_rd_en", i), o_rd_en, tbl[i].e_rd);
      chk($sformatf("v%0d_addr", i), o_rd_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_pix_valid", i), o_pixel_valid, tbl[i].e_pv);
      chk($sformatf("v%0d_busy", i), o_busy, tbl[i].e_busy);
      chk($sformatf("v%0d_done", i), o_done, tbl[i].e_done);
      chk($sformatf("v%0d_err", i), o_err, 0);
      if (tbl[i].e_pv) chk($sformatf("v%0d_pixel", i), o_pixel, tbl[i].e_pix);
    end

    // Run on to address 400, then pull reset mid-cycle.
    k = 0;
    while (!(o_rd_en === 1'b1 && o_rd_addr === 10'd400) && k < 1000) begin
      tick(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("reach_addr_400", (o_rd_en === 1'b1 && o_rd_addr === 10'd400), 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_pix_valid", o_pixel_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Stray beats in IDLE, then a clean frame needing the full 144 beats.
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (o_busy !== 1'b0 || o_rd_en !== 1'b0) errs++;
    end
    chk("idle_stray_beats", errs, 0);
    feed_frame(-1, 0, -1, 0, last, hpv);
    chk("basic_last_read_cycle", last, 784);
    drain(NPOOL, 1'b0);

    // Hold at 100 for 3 cycles, second start at cycle 50.
    feed_frame(100, 3, 50, 0, last, hpv);
    chk("hold_last_read_cycle", last, 787);
    chk("hold_pixels_delivered", hpv, 1);
    errs = 0;
    for (int i = 0; i < NPOOL - 1; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (o_done !== 1'b0 || o_busy !== 1'b1) errs++;
    end
    chk("beats_143_no_done", errs, 0);
`ifdef CNN_SEQ_TIMEOUT_EN
    errs = 0;
    for (int t = 1; t <= 17; t++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (o_done !== 1'b0) errs++;
      if (t < 17 && (o_err !== 1'b0 || o_busy !== 1'b1)) errs++;
      if (t == 17 && (o_err !== 1'b1 || o_busy !== 1'b0)) errs++;
    end
    chk("timeout_err_timing", errs, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("timeout_err_single", o_err, 0);
`else
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (o_done !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b1) errs++;
    end
    chk("drain_waits", errs, 0);
    tick(1'b0, 1'b0, 1'b1);
    chk("last_beat_cycle_done", o_done, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("hold_frame_done", o_done, 1);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (o_done !== 1'b0 || o_busy !== 1'b0) errs++;
    end
    chk("no_queued_start", errs, 0);
`endif

    // Four beats during FEED count towards the total; start again in the done cycle.
    feed_frame(-1, 0, -1, 4, last, hpv);
    chk("pool_feed_last_read_cycle", last, 784);
    drain(NPOOL - 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
